// File: rtl/fp_regfile_pkg.sv
// fp_regfile_pkg: default register file geometry and scoreboard vector type
package fp_regfile_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_RD = 3;
  localparam int DEF_DEPTH = 2 ** DEF_ADDR_WIDTH;
  typedef logic [DEF_DEPTH-1:0] busy_vec_t;
endpackage

// File: rtl/fp_scoreboard.sv
// fp_scoreboard: busy-bit array with issue reservation and writeback clear, issue wins on collision
module fp_scoreboard
  import fp_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     iss_valid,
  input  logic [ADDR_WIDTH-1:0]    iss_addr,
  output logic                     iss_ready,
  input  logic                     wb_en,
  input  logic [ADDR_WIDTH-1:0]    wb_addr,
  output logic [2**ADDR_WIDTH-1:0] busy_vec
);
  logic [2**ADDR_WIDTH-1:0] busy;
  assign busy_vec = busy;
  assign iss_ready = ~busy[iss_addr] | (wb_en & (wb_addr == iss_addr));
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      busy <= '0;
    end else begin
      if (wb_en) busy[wb_addr] <= 1'b0;
      if (iss_valid && iss_ready) busy[iss_addr] <= 1'b1;
    end
  end
endmodule

// File: rtl/fp_regfile_sb.sv
// fp_regfile_sb: FP register file with busy scoreboard; FP_REGFILE_BYPASS_EN enables write-through forwarding
module fp_regfile_sb
  import fp_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  output logic                         iss_ready,
  input  logic                         wb_en,
  input  logic [ADDR_WIDTH-1:0]        wb_addr,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  output logic [2**ADDR_WIDTH-1:0]     busy_vec
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  fp_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .iss_valid(iss_valid),
    .iss_addr(iss_addr),
    .iss_ready(iss_ready),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .busy_vec(busy_vec)
  );
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
    end else if (wb_en) begin
      mem[wb_addr] <= wb_data;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef FP_REGFILE_BYPASS_EN
    logic fwd;
    assign fwd = wb_en & (wb_addr == ra);
    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = fwd ? wb_data : mem[ra];
    assign rd_busy[i] = ~fwd & busy_vec[ra];
`else
    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
    assign rd_busy[i] = busy_vec[ra];
`endif
  end
endmodule

// File: tb/tb_fp_regfile_sb.sv
// tb_fp_regfile_sb: randomized and directed checks of fp_regfile_sb against an array-based reference model
module tb_fp_regfile_sb;
  import fp_regfile_pkg::*;
  logic Clk = 1'b0;
  logic Rst_n;
  logic [14:0] rd_addr;
  logic [191:0] rd_data;
  logic [2:0] rd_busy;
  logic iss_valid;
  logic [4:0] iss_addr;
  logic iss_ready;
  logic wb_en;
  logic [4:0] wb_addr;
  logic [63:0] wb_data;
  busy_vec_t busy_vec;
  logic [63:0] ref_mem [32];
  logic ref_busy [32];
  int checks = 0;
  int errors = 0;
`ifdef FP_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  fp_regfile_sb dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .iss_valid(iss_valid),
    .iss_addr(iss_addr),
    .iss_ready(iss_ready),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .busy_vec(busy_vec)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic iv, input logic [4:0] ia, input logic we, input logic [4:0] wa,
                     input logic [63:0] wd, input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    logic [4:0] ra [3];
    logic rdy, fwd;
    logic [31:0] bv;
    @(negedge Clk);
    iss_valid = iv; iss_addr = ia; wb_en = we; wb_addr = wa; wb_data = wd;
    rd_addr = {r2, r1, r0};
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    #1;
    rdy = !ref_busy[ia] || (we && wa == ia);
    for (int n = 0; n < 32; n++) bv[n] = ref_busy[n];
    chk("iss_ready", {63'd0, iss_ready}, {63'd0, rdy});
    chk("busy_vec", {32'd0, busy_vec}, {32'd0, bv});
    for (int p = 0; p < 3; p++) begin
      fwd = BYP && we && wa == ra[p];
      chk($sformatf("rd_data%0d@%0d", p, ra[p]), rd_data[p*64 +: 64], fwd ? wd : ref_mem[ra[p]]);
      chk($sformatf("rd_busy%0d@%0d", p, ra[p]), {63'd0, rd_busy[p]}, {63'd0, !fwd && ref_busy[ra[p]]});
    end
    @(posedge Clk);
    if (we) begin
      ref_mem[wa] = wd;
      ref_busy[wa] = 1'b0;
    end
    if (iv && rdy) ref_busy[ia] = 1'b1;
  endtask
  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0; iss_valid = 1'b0; wb_en = 1'b0;
    @(posedge Clk);
    for (int n = 0; n < 32; n++) begin
      ref_mem[n] = '0;
      ref_busy[n] = 1'b0;
    end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask
  task automatic sweep();
    for (int a = 0; a < 32; a++) cyc(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 5'(a), 5'(a), 5'(a));
  endtask
  initial begin
    Rst_n = 1'b0; rd_addr = '0; iss_valid = 1'b0; iss_addr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    for (int n = 0; n < 32; n++) begin
      ref_mem[n] = 64'hDEAD;
      ref_busy[n] = 1'b1;
    end
    do_reset();
    #1;
    chk("reset_busy_vec", {32'd0, busy_vec}, 64'd0);
    chk("reset_iss_ready", {63'd0, iss_ready}, 64'd1);
    sweep();
    cyc(1'b0, 5'd0, 1'b1, 5'd7, 64'h4000_0000_0000_0000, 5'd7, 5'd7, 5'd0);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd0, 5'd7);
    chk("wb7_read", rd_data[63:0], 64'h4000_0000_0000_0000);
    cyc(1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 5'd5, 5'd0, 5'd0);
    cyc(1'b1, 5'd5, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 5'd5);
    chk("waw_stall", {63'd0, iss_ready}, 64'd0);
    cyc(1'b1, 5'd5, 1'b1, 5'd5, 64'h3FF0_0000_0000_0000, 5'd5, 5'd1, 5'd2);
    chk("collide_ready", {63'd0, iss_ready}, 64'd1);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 5'd5);
    chk("collide_busy5", {63'd0, busy_vec[5]}, 64'd1);
    chk("collide_data5", rd_data[63:0], 64'h3FF0_0000_0000_0000);
    cyc(1'b1, 5'd1, 1'b1, 5'd9, 64'h1234, 5'd9, 5'd1, 5'd0);
    cyc(1'b1, 5'd2, 1'b1, 5'd0, 64'hABCD, 5'd2, 5'd9, 5'd0);
    cyc(1'b1, 5'd3, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 5'd0, 5'd31);
    cyc(1'b0, 5'd0, 1'b1, 5'd12, 64'h55, 5'd1, 5'd2, 5'd3);
    do_reset();
    #1;
    chk("midrst_busy_vec", {32'd0, busy_vec}, 64'd0);
    sweep();
    for (int k = 0; k < 1500; k++) begin
      logic [4:0] lim;
      lim = (k < 750) ? 5'd7 : 5'd31;
      if (k == 1000) do_reset();
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, lim)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, lim)), {$urandom, $urandom},
          5'($urandom_range(0, lim)), 5'($urandom_range(0, lim)), 5'($urandom_range(0, lim)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
